// File: rtl/fifo_read_streamer_if.sv
// Handshake bundle for fifo_read_streamer: FIFO read port on one side, ready/valid
// stream with frame marker on the other. master = streamer, slave = its environment.
interface fifo_read_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Clear_in;
  logic                  Empty_in;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  ReadEn_out;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  Valid_out;
  logic                  Ready_in;
  logic                  Last_out;

  modport master (
    input  Clear_in, Empty_in, Data_in, Ready_in,
    output ReadEn_out, Data_out, Valid_out, Last_out
  );

  modport slave (
    output Clear_in, Empty_in, Data_in, Ready_in,
    input  ReadEn_out, Data_out, Valid_out, Last_out
  );
endinterface

// File: rtl/fifo_read_streamer.sv
// Turns a FIFO read port (1-cycle read latency) into a bubble-free ready/valid stream
// through a 2-entry skid buffer. Define FIFO_READ_STREAMER_LAST_EN to build Last_out framing.
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  fifo_read_streamer_if.master sif
);
  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t      slot_q [2];
  word_t      slot_d [2];
  logic [1:0] occ_q;
  logic [1:0] occ_d;
  logic       inflight_q;

  logic       valid;
  logic       pop;
  logic       read_en;
  logic [2:0] committed;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid & sif.Ready_in;

  // Slots already promised after this edge: held words plus the returning read, minus the pop.
  assign committed = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};

  // Rst_n gates the read so no FIFO word is consumed while the buffer is held in reset.
  assign read_en = Rst_n & ~sif.Empty_in & ~sif.Clear_in & (committed < 3'd2);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    slot_d = slot_q;
    occ_d  = occ_q;
    if (sif.Clear_in) begin
      occ_d = 2'd0;
    end else begin
      if (pop) begin
        slot_d[0] = slot_q[1];
        occ_d     = occ_q - 2'd1;
      end
      // After any pop occ_d is 0 or 1 whenever a word is inflight, so bit 0 picks the free slot.
      if (inflight_q) begin
        slot_d[occ_d[0]] = sif.Data_in;
        occ_d            = occ_d + 2'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // NOTE: the two slots are reset because Data_out must read 0 in reset; deep storage would not be.
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      slot_q[0]  <= slot_d[0];
      slot_q[1]  <= slot_d[1];
      occ_q      <= occ_d;
      inflight_q <= read_en;
    end
  end

  assign sif.ReadEn_out = read_en;
  assign sif.Valid_out  = valid;
  assign sif.Data_out   = slot_q[0];

`ifdef FIFO_READ_STREAMER_LAST_EN
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic [15:0] frame_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_cnt_q <= 16'd0;
    end else if (sif.Clear_in) begin
      frame_cnt_q <= 16'd0;
    end else if (pop) begin
      frame_cnt_q <= (frame_cnt_q == LAST_IDX) ? 16'd0 : frame_cnt_q + 16'd1;
    end
  end

  assign sif.Last_out = valid & (frame_cnt_q == LAST_IDX);
`else
  // Frame length only matters when framing is built.
  logic frame_len_unused;
  assign frame_len_unused = (FRAME_LEN == 0);
  assign sif.Last_out     = 1'b0;
`endif

endmodule
